// File: rtl/multi_wave_generator.sv
// Phase-accumulator waveform source: square (programmable duty), sawtooth,
// triangle or DC level. New settings wait in a shadow register and take
// effect at the next period boundary, or at once while the generator is idle.
module multi_wave_generator #(
    parameter int WIDTH      = 8,
    parameter int ACC_W      = 16,
    parameter int RESET_STEP = 256,
    parameter int RESET_DUTY = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             cfg_pending,
    output logic [WIDTH-1:0] wave_out,
    output logic             wrap
);

    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}};

    logic [ACC_W-1:0] phase;
    logic [1:0]       act_mode;
    logic [ACC_W-1:0] act_step;
    logic [WIDTH-1:0] act_duty;
    logic [1:0]       pend_mode;
    logic [ACC_W-1:0] pend_step;
    logic [WIDTH-1:0] pend_duty;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply_cfg;
    logic [WIDTH-1:0] t_val;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] sample;

    // Next phase, period-boundary detection and the sample for the current phase.
    always_comb begin
        sum       = {1'b0, phase} + {1'b0, act_step};
        carry     = sum[ACC_W];
        // Idle applies pending settings immediately; running applies them at the wrap.
        apply_cfg = !enable || carry;
        t_val     = phase[ACC_W-1 -: WIDTH];
        r_val     = phase[ACC_W-2 -: WIDTH];
        sample    = '0;
        case (act_mode)
            MODE_SQUARE: sample = (t_val < act_duty) ? MAX : '0;
            MODE_SAW:    sample = t_val;
            MODE_TRI:    sample = phase[ACC_W-1] ? ~r_val : r_val;
            default:     sample = act_duty;
        endcase
    end

    // Accumulator, registered outputs and shadow/active configuration handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            wave_out    <= '0;
            wrap        <= 1'b0;
            cfg_pending <= 1'b0;
            act_mode    <= MODE_SQUARE;
            act_step    <= ACC_W'(RESET_STEP);
            act_duty    <= WIDTH'(RESET_DUTY);
            pend_mode   <= MODE_SQUARE;
            pend_step   <= '0;
            pend_duty   <= '0;
        end else begin
            if (cfg_we) begin
                pend_mode <= cfg_mode;
                pend_step <= cfg_step;
                pend_duty <= cfg_duty;
            end

            if (!enable) begin
                phase    <= '0;
                wave_out <= '0;
                wrap     <= 1'b0;
            end else begin
                phase    <= sum[ACC_W-1:0];
                wave_out <= sample;
                wrap     <= carry;
            end

            if (apply_cfg) begin
                // A write landing on the boundary cycle goes straight to active.
                if (cfg_we) begin
                    act_mode <= cfg_mode;
                    act_step <= cfg_step;
                    act_duty <= cfg_duty;
                end else if (cfg_pending) begin
                    act_mode <= pend_mode;
                    act_step <= pend_step;
                    act_duty <= pend_duty;
                end
                cfg_pending <= 1'b0;
            end else if (cfg_we) begin
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_wave_generator.sv
// Directed bench for multi_wave_generator with WIDTH=8, ACC_W=16.
module tb_multi_wave_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_we;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_step;
    logic [7:0]  cfg_duty;
    logic        cfg_pending;
    logic [7:0]  wave_out;
    logic        wrap;

    int n_cmp = 0;
    int n_err = 0;

    multi_wave_generator #(
        .WIDTH(8), .ACC_W(16), .RESET_STEP(256), .RESET_DUTY(128)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_duty(cfg_duty),
        .cfg_pending(cfg_pending), .wave_out(wave_out), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input int k, input int exp_wave, input int exp_wrap, input int exp_pend);
        check({tag, ".wave"}, k, 32'(wave_out), 32'(exp_wave));
        check({tag, ".wrap"}, k, 32'(wrap), 32'(exp_wrap));
        check({tag, ".pend"}, k, 32'(cfg_pending), 32'(exp_pend));
    endtask

    // Configure while idle: settings apply at once, outputs forced to zero.
    task automatic cfg_idle(input string tag, input logic [1:0] m, input logic [15:0] s, input logic [7:0] d);
        enable   = 1'b0;
        cfg_we   = 1'b1;
        cfg_mode = m;
        cfg_step = s;
        cfg_duty = d;
        tick();
        cfg_we   = 1'b0;
        chk_out(tag, 0, 0, 0, 0);
    endtask

    function automatic int sq_exp(input int t, input int duty);
        return (t < duty) ? 255 : 0;
    endfunction

    function automatic int tri_exp(input int j);
        int p;
        p = j % 128;
        return (p < 64) ? 4 * p : 255 - 4 * (p - 64);
    endfunction

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        cfg_we   = 1'b0;
        cfg_mode = 2'd0;
        cfg_step = 16'h0000;
        cfg_duty = 8'h00;

        // Reset and default square: 255 for T<128, period 256 cycles.
        repeat (3) tick();
        chk_out("reset", 0, 0, 0, 0);
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            tick();
            chk_out("dflt_sq", k, sq_exp((k - 1) % 256, 128), int'(k % 256 == 0), 0);
        end

        // Sawtooth, step 0x0100.
        cfg_idle("saw_cfg", 2'd1, 16'h0100, 8'd128);
        enable = 1'b1;
        for (int k = 1; k <= 258; k++) begin
            tick();
            chk_out("saw", k, (k - 1) % 256, int'(k == 256), 0);
        end

        // Triangle, step 0x0200, period 128.
        cfg_idle("tri_cfg", 2'd2, 16'h0200, 8'd128);
        enable = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk_out("tri", k, tri_exp(k - 1), int'(k % 128 == 0), 0);
        end

        // Deferred application at wrap, then a write coincident with the carry.
        cfg_idle("defer_cfg", 2'd0, 16'h0100, 8'd128);
        enable = 1'b1;
        for (int k = 1; k <= 530; k++) begin
            cfg_we = 1'b0;
            if (k == 65) begin
                cfg_we = 1'b1; cfg_mode = 2'd1; cfg_step = 16'h0100; cfg_duty = 8'd128;
            end else if (k == 512) begin
                cfg_we = 1'b1; cfg_mode = 2'd2; cfg_step = 16'h0200; cfg_duty = 8'd128;
            end
            tick();
            if (k <= 256)
                chk_out("defer", k, sq_exp(k - 1, 128), int'(k == 256), int'(k >= 65 && k < 256));
            else if (k <= 512)
                chk_out("defer", k, (k - 1) % 256, int'(k == 512), 0);
            else
                chk_out("defer", k, tri_exp(k - 513), 0, 0);
        end
        cfg_we = 1'b0;

        // Drop enable at phase 0x8000 with a pending config.
        cfg_idle("drop_cfg", 2'd0, 16'h0100, 8'd128);
        enable = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            cfg_we = 1'b0;
            if (k == 100) begin
                cfg_we = 1'b1; cfg_mode = 2'd1; cfg_step = 16'h0100; cfg_duty = 8'd128;
            end
            tick();
            chk_out("drop_run", k, 255, 0, int'(k >= 100));
        end
        cfg_we = 1'b0;
        enable = 1'b0;
        tick();
        chk_out("drop_idle", 0, 0, 0, 0);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_out("drop_resume", k, k - 1, 0, 0);
        end

        // Duty 0: constant low, wrap still pulses.
        cfg_idle("duty0_cfg", 2'd0, 16'h0100, 8'd0);
        enable = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk_out("duty0", k, 0, int'(k == 256), 0);
        end

        // Duty 255: one low sample per period (T==255).
        cfg_idle("duty255_cfg", 2'd0, 16'h0100, 8'd255);
        enable = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            tick();
            chk_out("duty255", k, (k == 256) ? 0 : 255, int'(k == 256), 0);
        end

        // Step 0: phase frozen at 0, square high, no wrap.
        cfg_idle("step0_cfg", 2'd0, 16'h0000, 8'd128);
        enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_out("step0", k, 255, 0, 0);
        end

        // DC level 0x5A.
        cfg_idle("dc_cfg", 2'd3, 16'h0100, 8'h5A);
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk_out("dc", k, 8'h5A, 0, 0);
        end

        // Reset mid-run with pending config; reset wins over cfg_we and enable.
        cfg_we = 1'b1; cfg_mode = 2'd3; cfg_step = 16'h0100; cfg_duty = 8'h11;
        tick();
        chk_out("pre_rst", 0, 8'h5A, 0, 1);
        reset = 1'b1;
        tick();
        chk_out("mid_rst", 0, 0, 0, 0);
        reset  = 1'b0;
        cfg_we = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk_out("post_rst", k, sq_exp((k - 1) % 256, 128), int'(k == 256), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
